// File: rtl/tqvp_prism_counter_bank.sv
// tqvp_prism_counter_bank: CHANNELS x WIDTH timer/counter bank for PRISM.
// Ports: TinyQV bus (address, data_in, data_write_n, data_read_n,
//   data_out, data_ready), FSM side (halt, fsm_enable, step, load, hit),
//   and user_interrupt (OR of enabled sticky flags).
module tqvp_prism_counter_bank #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 27
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [5:0]          address,
    input  logic [31:0]         data_in,
    input  logic [1:0]          data_write_n,
    input  logic [1:0]          data_read_n,
    output logic [31:0]         data_out,
    output logic                data_ready,
    input  logic                halt,
    input  logic                fsm_enable,
    input  logic [CHANNELS-1:0] step,
    input  logic [CHANNELS-1:0] load,
    output logic [CHANNELS-1:0] hit,
    output logic                user_interrupt
);

    logic [WIDTH-1:0]    count_q   [CHANNELS];
    logic [WIDTH-1:0]    count_d   [CHANNELS];
    logic [WIDTH-1:0]    preload_q [CHANNELS];
    logic [WIDTH-1:0]    preload_d [CHANNELS];
    logic [CHANNELS-1:0] mode_q;
    logic [CHANNELS-1:0] mode_d;
    logic [CHANNELS-1:0] irq_en_q;
    logic [CHANNELS-1:0] irq_en_d;
    logic [CHANNELS-1:0] flag_q;
    logic [CHANNELS-1:0] flag_d;
    logic [CHANNELS-1:0] hit_prev_q;
    logic [CHANNELS-1:0] hit_prev_d;

    logic                wr_en;
    logic                sel_ctrl;
    logic                sel_status;
    logic                sel_chan;
    logic [2:0]          chan_idx;
    logic [CHANNELS-1:0] do_step;
    logic [CHANNELS-1:0] do_load;
    logic [CHANNELS-1:0] hit_rise;
    logic                unused_ok;

    assign wr_en      = (data_write_n == 2'b10);
    assign sel_ctrl   = (address == 6'h00);
    assign sel_status = (address == 6'h04);
    assign sel_chan   = address[5] && (address[1:0] == 2'b00);
    assign chan_idx   = address[4:2];

    // step together with load is a reserved encoding: neither acts.
    assign do_step = step & ~load & {CHANNELS{~halt}};
    assign do_load = load & ~step & {CHANNELS{fsm_enable & ~halt}};

    assign hit_rise       = hit & ~hit_prev_q;
    assign user_interrupt = |(flag_q & irq_en_q);
    assign data_ready     = 1'b1;
    assign unused_ok      = &{1'b0, data_read_n, data_in};

    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (mode_q[c]) begin
                hit[c] = (count_q[c] == preload_q[c]);
            end else begin
                hit[c] = (count_q[c] == '0);
            end
        end
    end

    always_comb begin
        mode_d     = mode_q;
        irq_en_d   = irq_en_q;
        hit_prev_d = hit;
        flag_d     = flag_q | hit_rise;
        if (wr_en && sel_ctrl) begin
            mode_d   = data_in[CHANNELS-1:0];
            irq_en_d = data_in[8 +: CHANNELS];
        end
        // A new rising edge wins over a W1C in the same cycle.
        if (wr_en && sel_status) begin
            flag_d = (flag_q & ~data_in[CHANNELS-1:0]) | hit_rise;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            preload_d[c] = preload_q[c];
            count_d[c]   = count_q[c];
            if (wr_en && sel_chan && (chan_idx == 3'(c))) begin
                preload_d[c] = data_in[WIDTH-1:0];
            end
            if (do_step[c]) begin
                if (mode_q[c]) begin
                    count_d[c] = count_q[c] + WIDTH'(1);
                end else if (count_q[c] != '0) begin
                    count_d[c] = count_q[c] - WIDTH'(1);
                end
            end else if (do_load[c]) begin
                count_d[c] = mode_q[c] ? '0 : preload_q[c];
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (sel_ctrl) begin
            data_out[CHANNELS-1:0]  = mode_q;
            data_out[8 +: CHANNELS] = irq_en_q;
        end else if (sel_status) begin
            data_out[CHANNELS-1:0]   = flag_q;
            data_out[16 +: CHANNELS] = hit;
        end else if (sel_chan) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (chan_idx == 3'(c)) begin
                    data_out[WIDTH-1:0] = count_q[c];
                end
            end
        end
    end

    // hit_prev resets high so the post-reset hit=1 is not a rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= '0;
                preload_q[c] <= '0;
            end
            mode_q     <= '0;
            irq_en_q   <= '0;
            flag_q     <= '0;
            hit_prev_q <= '1;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                count_q[c]   <= count_d[c];
                preload_q[c] <= preload_d[c];
            end
            mode_q     <= mode_d;
            irq_en_q   <= irq_en_d;
            flag_q     <= flag_d;
            hit_prev_q <= hit_prev_d;
        end
    end

endmodule

// File: tb/tb_tqvp_prism_counter_bank.sv
// tb_tqvp_prism_counter_bank: directed + random bench for the counter bank.
// Two instances (WIDTH 27 and 4) share stimulus; a behavioural model checks.
module tb_tqvp_prism_counter_bank;

    localparam int CH = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    address = '0;
    logic [31:0]   data_in = '0;
    logic [1:0]    data_write_n = 2'b11;
    logic [1:0]    data_read_n = 2'b11;
    logic          halt = 1'b0;
    logic          fsm_enable = 1'b0;
    logic [CH-1:0] step = '0;
    logic [CH-1:0] load = '0;

    logic [31:0]   dout_a, dout_b;
    logic          rdy_a, rdy_b;
    logic [CH-1:0] hit_a, hit_b;
    logic          irq_a, irq_b;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    tqvp_prism_counter_bank #(.CHANNELS(CH), .WIDTH(27)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(dout_a), .data_ready(rdy_a), .halt(halt),
        .fsm_enable(fsm_enable), .step(step), .load(load),
        .hit(hit_a), .user_interrupt(irq_a)
    );

    tqvp_prism_counter_bank #(.CHANNELS(CH), .WIDTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
        .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(dout_b), .data_ready(rdy_b), .halt(halt),
        .fsm_enable(fsm_enable), .step(step), .load(load),
        .hit(hit_b), .user_interrupt(irq_b)
    );

    // Behavioural model: index 0 = WIDTH 27, index 1 = WIDTH 4.
    longint unsigned m_cnt [2][CH];
    longint unsigned m_pre [2][CH];
    bit              m_flag [2][CH];
    bit              m_hprev [2][CH];
    bit              m_mode [CH];
    bit              m_ien [CH];
    int              m_w [2] = '{27, 4};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_hit(int i, int c);
        if (m_mode[c]) return m_cnt[i][c] == m_pre[i][c];
        return m_cnt[i][c] == 0;
    endfunction

    function automatic logic [31:0] m_read(int i, logic [5:0] a);
        logic [31:0] r;
        int          ch;
        r = '0;
        ch = (int'(a) - 32) / 4;
        if (a == 6'h00) begin
            for (int c = 0; c < CH; c++) begin
                r[c]     = m_mode[c];
                r[8 + c] = m_ien[c];
            end
        end else if (a == 6'h04) begin
            for (int c = 0; c < CH; c++) begin
                r[c]      = m_flag[i][c];
                r[16 + c] = m_hit(i, c);
            end
        end else if (a >= 6'h20 && a[1:0] == 2'b00 && ch < CH) begin
            r = 32'(m_cnt[i][ch]);
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            for (int c = 0; c < CH; c++) begin
                m_cnt[i][c]   = 0;
                m_pre[i][c]   = 0;
                m_flag[i][c]  = 0;
                m_hprev[i][c] = 1;
            end
        end
        for (int c = 0; c < CH; c++) begin
            m_mode[c] = 0;
            m_ien[c]  = 0;
        end
    endtask

    task automatic m_edge();
        bit              wr;
        bit              h;
        longint unsigned mask;
        wr = (data_write_n == 2'b10);
        for (int i = 0; i < 2; i++) begin
            mask = (64'd1 << m_w[i]) - 1;
            for (int c = 0; c < CH; c++) begin
                h = m_hit(i, c);
                if (wr && address == 6'h04 && data_in[c]) m_flag[i][c] = 0;
                if (h && !m_hprev[i][c]) m_flag[i][c] = 1;
                m_hprev[i][c] = h;
                if (!halt && step[c] && !load[c]) begin
                    if (m_mode[c]) m_cnt[i][c] = (m_cnt[i][c] + 1) % (mask + 1);
                    else if (m_cnt[i][c] != 0) m_cnt[i][c] = m_cnt[i][c] - 1;
                end else if (!halt && load[c] && !step[c] && fsm_enable) begin
                    m_cnt[i][c] = m_mode[c] ? 0 : m_pre[i][c];
                end
                if (wr && address == 6'(32 + 4 * c))
                    m_pre[i][c] = longint'(data_in) & mask;
            end
        end
        if (wr && address == 6'h00) begin
            for (int c = 0; c < CH; c++) begin
                m_mode[c] = data_in[c];
                m_ien[c]  = data_in[8 + c];
            end
        end
    endtask

    task automatic check_all();
        logic [CH-1:0] eh;
        bit            ei;
        for (int i = 0; i < 2; i++) begin
            ei = 0;
            for (int c = 0; c < CH; c++) begin
                eh[c] = m_hit(i, c);
                if (m_flag[i][c] && m_ien[c]) ei = 1;
            end
            chk(i ? "hit_b" : "hit_a", i ? 32'(hit_b) : 32'(hit_a), 32'(eh));
            chk(i ? "irq_b" : "irq_a", i ? 32'(irq_b) : 32'(irq_a), 32'(ei));
            chk(i ? "rd_b" : "rd_a", i ? dout_b : dout_a, m_read(i, address));
            chk(i ? "rdy_b" : "rdy_a", i ? 32'(rdy_b) : 32'(rdy_a), 32'd1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
        check_all();
    endtask

    task automatic wr32(input logic [5:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        data_write_n = 2'b10;
        tick();
        data_write_n = 2'b11;
    endtask

    task automatic peek(input string tag, input int i, input logic [5:0] a,
                        input logic [31:0] exp);
        address = a;
        #1;
        chk(tag, i ? dout_b : dout_a, exp);
    endtask

    initial begin
        m_reset();
        #3;
        check_all();
        chk("rst_hit", 32'(hit_a), 32'hF);
        #4;
        rst_n = 1'b1;
        tick();

        // Down-count, interrupt, W1C
        wr32(6'h20, 32'd5);
        fsm_enable = 1'b1;
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        wr32(6'h00, 32'h0000_0100);
        address = 6'h20;
        step[0] = 1'b1;
        repeat (5) tick();
        peek("cnt0_zero", 0, 6'h20, 32'd0);
        chk("hit0_rise", 32'(hit_a[0]), 32'd1);
        tick();
        step[0] = 1'b0;
        chk("irq0_set", 32'(irq_a), 32'd1);
        peek("cnt0_hold", 0, 6'h20, 32'd0);
        wr32(6'h04, 32'h1);
        chk("irq0_clr", 32'(irq_a), 32'd0);

        // Up-count compare and wrap
        wr32(6'h00, 32'h0000_0102);
        wr32(6'h24, 32'd3);
        step[1] = 1'b1;
        repeat (3) tick();
        step[1] = 1'b0;
        chk("hit1_cmp", 32'(hit_a[1]), 32'd1);
        tick();
        address = 6'h04;
        #1;
        chk("flag1_set", 32'(dout_a[1]), 32'd1);
        step[1] = 1'b1;
        repeat (13) tick();
        step[1] = 1'b0;
        peek("cnt1_wrap_b", 1, 6'h24, 32'd0);
        peek("cnt1_a", 0, 6'h24, 32'd16);

        // Halt and enable gating
        wr32(6'h28, 32'd7);
        load[2] = 1'b1;
        tick();
        load[2] = 1'b0;
        step[2] = 1'b1;
        tick();
        halt = 1'b1;
        repeat (10) tick();
        halt = 1'b0;
        step[2] = 1'b0;
        peek("halt2", 0, 6'h28, 32'd6);
        fsm_enable = 1'b0;
        load[2] = 1'b1;
        tick();
        load[2] = 1'b0;
        fsm_enable = 1'b1;
        peek("noen2", 0, 6'h28, 32'd6);
        step[2] = 1'b1;
        load[2] = 1'b1;
        tick();
        step[2] = 1'b0;
        load[2] = 1'b0;
        peek("both2", 0, 6'h28, 32'd6);

        // Bus qualification
        for (int k = 0; k < 4; k++) begin
            address = (k % 2 == 0) ? 6'h00 : 6'h20;
            data_in = 32'hFFFF_FFFF;
            data_write_n = (k < 2) ? 2'b00 : 2'b01;
            tick();
        end
        data_write_n = 2'b11;
        peek("ctrl_kept", 0, 6'h00, 32'h0000_0102);
        peek("rd_3c", 0, 6'h3C, 32'd0);
        load[0] = 1'b1;
        tick();
        load[0] = 1'b0;
        peek("pre0_kept", 0, 6'h20, 32'd5);

        // Flag set vs clear race
        wr32(6'h2C, 32'd2);
        load[3] = 1'b1;
        tick();
        load[3] = 1'b0;
        step[3] = 1'b1;
        repeat (2) tick();
        step[3] = 1'b0;
        wr32(6'h04, 32'h8);
        address = 6'h04;
        #1;
        chk("race_flag3", 32'(dout_a[3]), 32'd1);

        // Reset mid-count
        wr32(6'h2C, 32'd100);
        load[3] = 1'b1;
        tick();
        load[3] = 1'b0;
        peek("cnt3_100", 0, 6'h2C, 32'd100);
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("rst_hit_all", 32'(hit_a), 32'hF);
        chk("rst_irq", 32'(irq_a), 32'd0);
        peek("rst_cnt3", 0, 6'h2C, 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (3) tick();
        peek("rst_noflag", 0, 6'h04, 32'h000F_0000);

        // Random phase
        for (int n = 0; n < 500; n++) begin
            step = 4'($urandom);
            load = 4'($urandom) & 4'($urandom);
            halt = ($urandom_range(0, 15) == 0);
            fsm_enable = ($urandom_range(0, 3) != 0);
            data_write_n = 2'b11;
            case ($urandom_range(0, 5))
                0: address = 6'h00;
                1, 5: address = 6'h04;
                2, 3: address = 6'(32 + 4 * $urandom_range(0, 7));
                default: address = 6'($urandom);
            endcase
            data_in = $urandom;
            if (address >= 6'h20) data_in = $urandom_range(0, 20);
            if ($urandom_range(0, 3) == 0) data_write_n = 2'($urandom);
            tick();
        end
        data_write_n = 2'b11;

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
